// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Command handshake between a client (master) and the PS/2 host transmitter
// (slave).
//   tx_valid   master -> slave  command byte request, held until accepted
//   tx_data    master -> slave  command byte, sampled on tx_valid && tx_ready
//   tx_ready   slave -> master  transmitter idle and able to accept
//   tx_done    slave -> master  1-cycle pulse: frame sent and ACK(0) seen
//   tx_error   slave -> master  1-cycle pulse: NACK or timeout
//   tx_inhibit slave -> master  busy; the PS/2 receiver must ignore the bus
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       tx_inhibit;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx_done,
    input  tx_error,
    input  tx_inhibit
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx_done,
    output tx_error,
    output tx_inhibit
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// over the shared open-drain k_clk/k_data pair:
//   start(0), D0..D7 LSB first, odd parity, stop(1), device ACK(0).
// The host first holds k_clk low (inhibit), then pulls k_data low and
// releases k_clk (request-to-send); the device then generates the clock and
// the host changes data on each falling edge.
//
// Ports
//   clk               system clock
//   reset_n           asynchronous active-low reset
//   host              ps2_host_tx_if.slave command handshake
//   kb_clk_in         raw k_clk pin level (asynchronous)
//   kb_data_in        raw k_data pin level (asynchronous)
//   kb_clk_drive_low  1 = pull k_clk low, 0 = release
//   kb_data_drive_low 1 = pull k_data low, 0 = release
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int START_TIMEOUT  = 1_500_000,
  parameter int FRAME_TIMEOUT  = 200_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  ps2_host_tx_if.slave       host,
  input  logic               kb_clk_in,
  input  logic               kb_data_in,
  output logic               kb_clk_drive_low,
  output logic               kb_data_drive_low
);

  localparam int TO_MAX = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int TO_W   = $clog2(TO_MAX + 1);
  localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int FLT_W  = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_sync;
  logic             data_sync;
  logic             clk_filt_q;
  logic             clk_filt_d1_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic             fall;

  // Both pins idle high (pulled up), so the synchronizers reset to 1 to
  // avoid a spurious edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], kb_clk_in};
      data_sync_q <= {data_sync_q[0], kb_data_in};
    end
  end

  assign clk_sync  = clk_sync_q[1];
  assign data_sync = data_sync_q[1];

  // The filtered clock only follows the synced clock once it has disagreed
  // for FILTER_LEN consecutive samples; any agreeing sample restarts the
  // count, so short glitches on the cable never reach the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt_q    <= 1'b1;
      clk_filt_d1_q <= 1'b1;
      flt_cnt_q     <= '0;
    end else begin
      clk_filt_d1_q <= clk_filt_q;
      if (clk_sync == clk_filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt_q <= clk_sync;
        flt_cnt_q  <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d1_q & ~clk_filt_q;

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             parity_q, parity_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             first_fall_q, first_fall_d;
  logic             ack_ok_q, ack_ok_d;
  logic             data_low_q, data_low_d;
  logic             done_pulse;
  logic             error_pulse;
  logic             timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      byte_q       <= '0;
      parity_q     <= 1'b0;
      inh_cnt_q    <= '0;
      to_cnt_q     <= '0;
      first_fall_q <= 1'b0;
      ack_ok_q     <= 1'b0;
      data_low_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_q       <= byte_d;
      parity_q     <= parity_d;
      inh_cnt_q    <= inh_cnt_d;
      to_cnt_q     <= to_cnt_d;
      first_fall_q <= first_fall_d;
      ack_ok_q     <= ack_ok_d;
      data_low_q   <= data_low_d;
    end
  end

  // Until the device produces its first falling edge the counter measures
  // the start-up window; the first edge restarts it for the whole frame.
  assign timeout = first_fall_q ? (to_cnt_q >= TO_W'(FRAME_TIMEOUT))
                                : (to_cnt_q >= TO_W'(START_TIMEOUT));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_d       = byte_q;
    parity_d     = parity_q;
    inh_cnt_d    = inh_cnt_q;
    to_cnt_d     = to_cnt_q;
    first_fall_d = first_fall_q;
    ack_ok_d     = ack_ok_q;
    data_low_d   = data_low_q;
    done_pulse   = 1'b0;
    error_pulse  = 1'b0;

    unique case (state_q)
      IDLE: begin
        data_low_d = 1'b0;
        if (host.tx_valid) begin
          byte_d    = host.tx_data;
          parity_d  = ~^host.tx_data;
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          state_d = RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      // Start bit goes low while the clock is still held, so the device
      // sees request-to-send the moment the clock is released.
      RTS: begin
        to_cnt_d     = '0;
        first_fall_d = 1'b0;
        data_low_d   = 1'b1;
        state_d      = SHIFT;
      end

      SHIFT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (timeout) begin
          error_pulse = 1'b1;
          data_low_d  = 1'b0;
          state_d     = IDLE;
        end else if (fall) begin
          if (!first_fall_q) begin
            to_cnt_d     = '0;
            first_fall_d = 1'b1;
          end
          if (bit_cnt_q < 4'd8) begin
            data_low_d = ~byte_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_low_d = ~parity_q;
          end else begin
            data_low_d = 1'b0;
          end
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) begin
            state_d = ACK;
          end
        end
      end

      ACK: begin
        to_cnt_d   = to_cnt_q + 1'b1;
        data_low_d = 1'b0;
        if (timeout) begin
          error_pulse = 1'b1;
          state_d     = IDLE;
        end else if (fall) begin
          ack_ok_d = ~data_sync;
          state_d  = WAIT_IDLE;
        end
      end

      // The result is reported only once the device has let go of both
      // lines, so the receiver never resumes in the middle of the ACK bit.
      WAIT_IDLE: begin
        if (clk_filt_q && data_sync) begin
          done_pulse  = ack_ok_q;
          error_pulse = ~ack_ok_q;
          state_d     = IDLE;
        end
      end

      default: begin
        data_low_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Line drives decode directly from the state register so that an
  // asynchronous reset releases both lines without waiting for a clock edge.
  assign kb_clk_drive_low  = (state_q == INHIBIT) || (state_q == RTS);
  assign kb_data_drive_low = (state_q == RTS) || ((state_q == SHIFT) && data_low_q);

  assign host.tx_ready   = (state_q == IDLE);
  assign host.tx_inhibit = (state_q != IDLE);
  assign host.tx_done    = done_pulse;
  assign host.tx_error   = error_pulse;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard model on
// an open-drain bus. Expected frame bits are queued when a command is sent
// and consumed as the keyboard model clocks them out.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int STO  = 2000;
  localparam int FTO  = 3000;
  localparam int FLT  = 8;
  localparam int HALF = 50;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic kb_clk_in;
  logic kb_data_in;
  logic kb_clk_drive_low;
  logic kb_data_drive_low;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int accepts = 0;
  bit exp_q[$];

  ps2_host_tx_if host_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .FRAME_TIMEOUT  (FTO),
    .FILTER_LEN     (FLT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .host              (host_if.slave),
    .kb_clk_in         (kb_clk_in),
    .kb_data_in        (kb_data_in),
    .kb_clk_drive_low  (kb_clk_drive_low),
    .kb_data_drive_low (kb_data_drive_low)
  );

  // Wired-AND bus with pull-ups
  assign kb_clk_in  = ~(kb_clk_drive_low | dev_clk_low);
  assign kb_data_in = ~(kb_data_drive_low | dev_data_low);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (host_if.tx_valid && host_if.tx_ready) accepts++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      if (b[i]) ones++;
    end
    exp_q.push_back((ones % 2) == 0);
    exp_q.push_back(1'b1);
  endtask

  // Request a byte, then check acceptance, inhibit length and RTS.
  task automatic apply_stimulus(input logic [7:0] b);
    int cnt;
    @(negedge clk);
    host_if.tx_valid = 1'b1;
    host_if.tx_data  = b;
    push_frame(b);
    @(negedge clk);
    host_if.tx_valid = 1'b0;
    check_output("ready_low_after_accept", host_if.tx_ready, 0);
    check_output("inhibit_busy", host_if.tx_inhibit, 1);
    cnt = 0;
    while (kb_clk_drive_low && !kb_data_drive_low && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    check_output("clk_low_before_data", cnt, INH);
    check_output("rts_clk_low", kb_clk_drive_low, 1);
    check_output("rts_data_low", kb_data_drive_low, 1);
    @(negedge clk);
    check_output("clk_released", kb_clk_drive_low, 0);
    check_output("start_bit_held", kb_data_drive_low, 1);
  endtask

  // Keyboard model: clocks n_pulses, samples data on each rising edge,
  // drives ACK before pulse 11 when ack_low, and optionally injects a short
  // low glitch in the high phase of pulse glitch_at.
  task automatic bfm_frame(input int n_pulses, input bit ack_low, input int glitch_at);
    bit got;
    bit expb;
    repeat (100) @(negedge clk);
    for (int i = 0; i < n_pulses; i++) begin
      if (i == 10) begin
        if (ack_low) dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      got = kb_data_in;
      if (i < 10) begin
        check_output("scoreboard_nonempty", exp_q.size() > 0, 1);
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
        check_output($sformatf("frame_bit%0d", i), got, expb);
      end
      if (i == 10) begin
        dev_data_low = 1'b0;
        return;
      end
      if (i == glitch_at) begin
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (4) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 24) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic wait_result(input string tag, input bit exp_done);
    int k;
    k = 0;
    while (!host_if.tx_done && !host_if.tx_error && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check_output({tag, "_in_time"}, k < 1000, 1);
    check_output({tag, "_done"}, host_if.tx_done, exp_done);
    check_output({tag, "_error"}, host_if.tx_error, !exp_done);
    check_output({tag, "_ready_during_pulse"}, host_if.tx_ready, 0);
    @(negedge clk);
    check_output({tag, "_done_one_cycle"}, host_if.tx_done, 0);
    check_output({tag, "_error_one_cycle"}, host_if.tx_error, 0);
    check_output({tag, "_ready_after"}, host_if.tx_ready, 1);
    check_output({tag, "_clk_released"}, kb_clk_drive_low, 0);
    check_output({tag, "_data_released"}, kb_data_drive_low, 0);
  endtask

  initial begin
    int k;
    int acc_before;
    host_if.tx_valid = 1'b0;
    host_if.tx_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_ready", host_if.tx_ready, 1);
    check_output("rst_done", host_if.tx_done, 0);
    check_output("rst_error", host_if.tx_error, 0);
    check_output("rst_inhibit", host_if.tx_inhibit, 0);
    check_output("rst_clk_drive", kb_clk_drive_low, 0);
    check_output("rst_data_drive", kb_data_drive_low, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] step 1: send 0xED with ACK");
    apply_stimulus(8'hED);
    bfm_frame(11, 1'b1, -1);
    wait_result("ed", 1'b1);
    check_output("ed_sb_drained", exp_q.size(), 0);

    $display("[TB] step 2: send 0x00 with ACK");
    apply_stimulus(8'h00);
    bfm_frame(11, 1'b1, -1);
    wait_result("zero", 1'b1);

    $display("[TB] step 3: send 0x01, device NACKs");
    apply_stimulus(8'h01);
    bfm_frame(11, 1'b0, -1);
    wait_result("nack", 1'b0);

    $display("[TB] step 4: device never clocks");
    apply_stimulus(8'h55);
    k = 0;
    while (!host_if.tx_error && k < 3 * STO) begin
      check_output("timeout_no_done", host_if.tx_done, 0);
      @(negedge clk);
      k++;
    end
    check_output("start_timeout_cycles", k, STO);
    check_output("timeout_error", host_if.tx_error, 1);
    @(negedge clk);
    check_output("timeout_error_one_cycle", host_if.tx_error, 0);
    check_output("timeout_ready", host_if.tx_ready, 1);
    check_output("timeout_clk_released", kb_clk_drive_low, 0);
    check_output("timeout_data_released", kb_data_drive_low, 0);
    exp_q.delete();

    $display("[TB] step 5: reset after 4th bit, then 0xFF");
    apply_stimulus(8'hC3);
    bfm_frame(4, 1'b1, -1);
    check_output("pre_reset_d3_low", kb_data_drive_low, 1);
    reset_n = 1'b0;
    #1;
    check_output("reset_clk_released", kb_clk_drive_low, 0);
    check_output("reset_data_released", kb_data_drive_low, 0);
    check_output("reset_ready", host_if.tx_ready, 1);
    check_output("reset_no_done", host_if.tx_done, 0);
    check_output("reset_no_error", host_if.tx_error, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    apply_stimulus(8'hFF);
    bfm_frame(11, 1'b1, -1);
    wait_result("ff", 1'b1);

    $display("[TB] step 6: clock glitch and tx_valid while busy");
    acc_before = accepts;
    apply_stimulus(8'hF4);
    host_if.tx_data = 8'h12;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      host_if.tx_valid = 1'b1;
      @(negedge clk);
      host_if.tx_valid = 1'b0;
    end
    bfm_frame(11, 1'b1, 3);
    wait_result("glitch", 1'b1);
    repeat (200) @(negedge clk);
    check_output("single_frame_accepted", accepts - acc_before, 1);
    check_output("bus_quiet_after", kb_clk_drive_low, 0);
    check_output("idle_after", host_if.tx_inhibit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
